score_display: RTL

Multi-digit, parametrised successor to the single-digit hex segment decoder. Converts a `WIDTH`-bit binary score to `DIGITS` seven-segment digits, in decimal or hex, and drives the board HEX displays. Decimal conversion is sequential (shift-add-3, one bit per cycle), with a load/busy/done handshake, optional leading-zero blanking and overflow indication. It sits between the game score counter and the HEX outputs.

---
 rtl/score_display_if.sv | 23 ++
 rtl/score_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - load/result handshake bundle between score source and score_display
interface score_display_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic                  load;
    logic [WIDTH-1:0]      value;
    logic                  hex_mode;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output load, value, hex_mode,
        input  busy, done, overflow, seg
    );

    modport slave (
        input  load, value, hex_mode,
        output busy, done, overflow, seg
    );
endinterface

// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to multi-digit seven-segment converter (decimal or hex)
module score_display #(
    parameter int WIDTH    = 10,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic            clk,
    input  logic            resetn,
    score_display_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = (WIDTH > BW) ? WIDTH : BW;
    localparam int SW = 7 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            mode_q, mode_d;
    logic            flag_q, flag_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [BW-1:0]   bcd_adj;
    logic [PW-1:0]   val_ext;
    logic            hex_ovf;
    logic [SW-1:0]   seg_disp;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble of 5 or more, ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Hex digits straight from the captured value; bits beyond the display width flag overflow
    always_comb begin
        val_ext = PW'(shift_q);
        hex_ovf = |(val_ext >> BW);
    end

    // Digit rendering: dashes on overflow, otherwise font with optional leading-zero blanking
    always_comb begin
        logic lead;
        lead     = 1'b1;
        seg_disp = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (flag_q) begin
                seg_disp[7*k +: 7] = 7'h3F;
            end else if (BLANK_LZ != 0 && lead && k != 0) begin
                seg_disp[7*k +: 7] = 7'h7F;
            end else begin
                seg_disp[7*k +: 7] = font(bcd_q[4*k +: 4]);
            end
        end
    end

    // Next-state and datapath control for IDLE -> CONVERT -> UPDATE
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        mode_d  = mode_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d = bus.value;
                    mode_d  = bus.hex_mode;
                    bcd_d   = '0;
                    flag_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (mode_q) begin
                    bcd_d   = val_ext[BW-1:0];
                    flag_d  = hex_ovf;
                    state_d = UPDATE;
                end else begin
                    bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    flag_d  = flag_q | bcd_adj[BW-1];
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH - 1)) begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                seg_d   = seg_disp;
                ovf_d   = flag_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset blanks the display and aborts any conversion
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            mode_q  <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            seg_q   <= '1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            mode_q  <= mode_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.seg      = seg_q;
endmodule
